// File: rtl/float_rec_arbiter.sv
// Round-robin arbiter sharing one fixed-latency F32 reciprocal unit among NUM_REQ requesters.
// Tags ride a delay line matched to the unit latency; results return in order through a credited FIFO.
module float_rec_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int REC_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
  output logic [DATA_WIDTH-1:0]         rec_x,
  input  logic [DATA_WIDTH-1:0]         rec_y,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_y,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int IFW = $clog2(REC_LAT + 2);

  typedef struct packed {
    logic                  valid;
    logic [IDW-1:0]        id;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] bval;
  } tag_t;

  typedef struct packed {
    logic [IDW-1:0]        id;
    logic [DATA_WIDTH-1:0] y;
  } entry_t;

  logic [IDW-1:0]        ptr;
  tag_t                  dl [REC_LAT+1];
  entry_t                mem [FIFO_DEPTH];
  logic [FPW-1:0]        wr_ptr;
  logic [FPW-1:0]        rd_ptr;
  logic [CW-1:0]         count;
  logic [IFW-1:0]        inflight;
  logic [NUM_REQ-1:0]    rot;
  logic                  credit_ok;
  logic                  grant_found;
  logic                  transfer;
  logic                  push;
  logic                  pop;
  logic [IDW-1:0]        grant_idx;
  logic [DATA_WIDTH-1:0] grant_x;
  logic                  special;
  logic [DATA_WIDTH-1:0] special_y;

  // Every tag in the delay line already owns a FIFO slot, so credit = tags + buffered entries.
  always_comb begin
    inflight = '0;
    for (int s = 0; s <= REC_LAT; s++) inflight = inflight + IFW'(dl[s].valid);
  end

  assign credit_ok = (int'(inflight) + int'(count)) < FIFO_DEPTH;

  always_comb begin
    rot         = NUM_REQ'({req_valid, req_valid} >> ptr);
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rot[k]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign transfer  = grant_found & credit_ok;
  assign req_ready = transfer ? (NUM_REQ'(1) << grant_idx) : '0;
  assign grant_x   = req_x[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Zero/denormal, infinity and NaN are resolved here and carried alongside the tag.
  always_comb begin
    special   = 1'b0;
    special_y = '0;
    if (grant_x[30:23] == 8'h00) begin
      special   = 1'b1;
      special_y = {grant_x[31], 31'h7F80_0000};
    end else if (grant_x[30:23] == 8'hFF) begin
      special   = 1'b1;
      special_y = (grant_x[22:0] == 23'd0) ? {grant_x[31], 31'h0} : 32'h7FC0_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      rec_x <= '0;
      for (int s = 0; s <= REC_LAT; s++) dl[s] <= '0;
    end else begin
      if (transfer) begin
        ptr   <= IDW'((int'(grant_idx) + 1) % NUM_REQ);
        rec_x <= grant_x;
      end
      dl[0] <= '{valid: transfer, id: grant_idx, bypass: special, bval: special_y};
      for (int s = 1; s <= REC_LAT; s++) dl[s] <= dl[s-1];
    end
  end

  assign push       = dl[REC_LAT].valid;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid & resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == FPW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == FPW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: dl[REC_LAT].id,
                               y:  dl[REC_LAT].bypass ? dl[REC_LAT].bval : rec_y};
  end

  assign resp_y  = resp_valid ? mem[rd_ptr].y  : '0;
  assign resp_id = resp_valid ? mem[rd_ptr].id : '0;

endmodule
